// File: rtl/dif_pair_buffer.sv
// Radix-2 DIF front end: buffers first half-frame, emits (x[k], x[k+N/2]) pairs; optional DIF_PAIR_FRAME_SYNC_EN adds in_sof/sync_err.
// Latency: pair registered on the edge accepting x[k+N/2], valid the next cycle. No backpressure; in_valid gaps stretch output.
package dif_pair_pkg;
    typedef struct packed {
        logic signed [15:0] r;
        logic signed [15:0] i;
    } complex_product_t;
endpackage

module dif_pair_buffer
    import dif_pair_pkg::*;
#(
    parameter  int N_POINTS = 8,
    localparam int HALF_W   = (N_POINTS > 2) ? $clog2(N_POINTS / 2) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  complex_product_t   in_data,
`ifdef DIF_PAIR_FRAME_SYNC_EN
    input  logic               in_sof,
    output logic               sync_err,
`endif
    output complex_product_t   A,
    output complex_product_t   B,
    output logic               out_valid,
    output logic [HALF_W-1:0]  out_idx,
    output logic               out_last,
    output logic               busy
);
    localparam int                HALF     = N_POINTS / 2;
    localparam logic [HALF_W-1:0] LAST_IDX = HALF_W'(HALF - 1);

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [HALF_W-1:0]  r_cnt, w_cnt_nxt;
    complex_product_t   r_buf [HALF];
    complex_product_t   r_a, r_b;
    logic               r_out_valid, r_out_last, r_busy;
    logic [HALF_W-1:0]  r_out_idx;
    logic               w_sof, w_cnt_last, w_pair_fire, w_buf_wr, w_busy_nxt;
    logic [HALF_W-1:0]  w_wr_idx;

`ifdef DIF_PAIR_FRAME_SYNC_EN
    logic r_sync_err;
    assign w_sof    = in_valid & in_sof;
    assign sync_err = r_sync_err;
`else
    assign w_sof    = 1'b0;
`endif

    assign w_cnt_last = (r_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_sof) begin
            // A start-of-frame sample is always x[0]; with N=2 it completes the first half.
            if (HALF == 1) begin
                w_state_nxt = PAIR;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = FILL;
                w_cnt_nxt   = HALF_W'(1);
            end
        end else if (in_valid) begin
            if (w_cnt_last) begin
                w_cnt_nxt   = '0;
                w_state_nxt = (r_state == FILL) ? PAIR : FILL;
            end else begin
                w_cnt_nxt   = r_cnt + HALF_W'(1);
            end
        end
    end

    always_comb begin
        w_pair_fire = in_valid & (r_state == PAIR) & ~w_sof;
        w_buf_wr    = in_valid & ((r_state == FILL) | w_sof);
        w_wr_idx    = w_sof ? '0 : r_cnt;
        w_busy_nxt  = (w_state_nxt == PAIR) | (w_cnt_nxt != '0);
    end

    // PAIR reads buf[k] on the same edge FILL of the next frame could overwrite it, so no bubble is needed.
    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_buf[w_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= w_pair_fire;
            r_out_last  <= w_pair_fire & w_cnt_last;
            r_busy      <= w_busy_nxt;
            if (w_pair_fire) begin
                r_a       <= r_buf[r_cnt];
                r_b       <= in_data;
                r_out_idx <= r_cnt;
            end
        end
    end

`ifdef DIF_PAIR_FRAME_SYNC_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_sof & ~((r_state == FILL) & (r_cnt == '0));
        end
    end
`endif

    assign A         = r_a;
    assign B         = r_b;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
